// File: rtl/ili9225_pkg.sv
// Shared ILI9225 definitions: register indices, pixel format, default panel
// geometry and the receiver state encoding.
package ili9225_pkg;

  localparam int H_RES_DEF = 176;
  localparam int V_RES_DEF = 220;

  localparam logic [7:0] REG_HADDR = 8'h20;
  localparam logic [7:0] REG_VADDR = 8'h21;
  localparam logic [7:0] REG_GRAM  = 8'h22;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DECODE
  } rx_state_t;

endpackage

// File: rtl/spi_line_sync.sv
// One SPI wire brought into the clk domain: optional inversion, 2-FF
// synchroniser, plus a third stage for rising-edge detection.
module spi_line_sync #(
  parameter bit INVERT  = 1'b0,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic sync,
  output logic rise
);

  logic [2:0] stage_q;

  // NOTE: flops use non-blocking assignments so every stage samples the
  // value the previous stage held before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stage_q <= {3{RST_VAL}};
    else      stage_q <= {stage_q[1:0], line ^ INVERT};
  end

  assign sync = stage_q[1];
  assign rise = stage_q[1] & ~stage_q[2];

endmodule

// File: rtl/ili9225_spi_receiver.sv
// Display-side ILI9225 4-wire SPI decoder: oversamples CS/SCK/MOSI/DC and
// emits register writes and addressed GRAM pixel writes.
module ili9225_spi_receiver
  import ili9225_pkg::*;
#(
  parameter int H_RES        = H_RES_DEF,
  parameter int V_RES        = V_RES_DEF,
  parameter int WORD_BITS    = 16,
  parameter bit INVERT_LINES = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_cs,
  input  logic                     spi_sck,
  input  logic                     spi_mosi,
  input  logic                     spi_dc,
  output logic                     reg_wr,
  output logic [7:0]               reg_addr,
  output logic [15:0]              reg_data,
  output logic                     pix_wr,
  output logic [15:0]              pix_data,
  output logic [$clog2(H_RES)-1:0] pix_x,
  output logic [$clog2(V_RES)-1:0] pix_y,
  output logic                     frame_done,
  output logic                     proto_err
);

  localparam int X_W   = $clog2(H_RES);
  localparam int Y_W   = $clog2(V_RES);
  localparam int CNT_W = $clog2(WORD_BITS);

  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WORD_BITS - 1);
  localparam logic [X_W-1:0]       X_LAST   = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]       Y_LAST   = Y_W'(V_RES - 1);
  localparam logic [WORD_BITS-1:0] H_MOD    = WORD_BITS'(H_RES);
  localparam logic [WORD_BITS-1:0] V_MOD    = WORD_BITS'(V_RES);

  logic       cs_s, sck_rise, mosi_s, dc_s;
  logic       unused_sck_level;
  logic [2:0] unused_rise;

  // CS resets to its inactive level so the FSM does not see a phantom frame.
  spi_line_sync #(.INVERT(INVERT_LINES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .line(spi_cs), .sync(cs_s), .rise(unused_rise[0]));
  spi_line_sync #(.INVERT(INVERT_LINES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .line(spi_sck), .sync(unused_sck_level), .rise(sck_rise));
  spi_line_sync #(.INVERT(INVERT_LINES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .line(spi_mosi), .sync(mosi_s), .rise(unused_rise[1]));
  spi_line_sync #(.INVERT(INVERT_LINES), .RST_VAL(1'b0)) u_sync_dc (
    .clk(clk), .rst(rst), .line(spi_dc), .sync(dc_s), .rise(unused_rise[2]));

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [WORD_BITS-1:0] shift_q;
  logic                 dc_q;
  logic [7:0]           index_q;
  logic [X_W-1:0]       x_q;
  logic [Y_W-1:0]       y_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!cs_s) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (cs_s)                                state_d = ST_IDLE;
        else if (sck_rise && bit_cnt_q == LAST_BIT) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_SHIFT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      dc_q       <= 1'b0;
      index_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      reg_wr     <= 1'b0;
      reg_addr   <= '0;
      reg_data   <= '0;
      pix_wr     <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      reg_wr     <= 1'b0;
      pix_wr     <= 1'b0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (!cs_s) bit_cnt_q <= '0;
        ST_SHIFT: begin
          if (cs_s) begin
            proto_err <= (bit_cnt_q != '0);
            bit_cnt_q <= '0;
          end else if (sck_rise) begin
            shift_q <= {shift_q[WORD_BITS-2:0], mosi_s};
            dc_q    <= dc_s;
            if (bit_cnt_q != LAST_BIT) bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_DECODE: begin
          bit_cnt_q <= '0;
          if (!dc_q) begin
            index_q <= shift_q[7:0];
          end else if (index_q == REG_GRAM) begin
            pix_wr     <= 1'b1;
            pix_data   <= shift_q[15:0];
            pix_x      <= x_q;
            pix_y      <= y_q;
            frame_done <= (x_q == X_LAST) && (y_q == Y_LAST);
            if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end else begin
            reg_wr   <= 1'b1;
            reg_addr <= index_q;
            reg_data <= shift_q[15:0];
            if (index_q == REG_HADDR) x_q <= X_W'(shift_q % H_MOD);
            if (index_q == REG_VADDR) y_q <= Y_W'(shift_q % V_MOD);
          end
        end
        default: bit_cnt_q <= '0;
      endcase
    end
  end

endmodule
